// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-subset core: one instruction at a time through a shared FSM,
// with a single ready/valid memory port used for both instruction fetch and data.
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC          = 32'h0000_0000,
    parameter bit          TRAP_ON_UNALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        retire,
    output logic [31:0] pc_out,
    output logic        halted,
    input  logic [4:0]  dbg_raddr,
    output logic [31:0] dbg_rdata
);
    typedef enum logic [2:0] {S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;

    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24;
    localparam logic [5:0] FN_OR = 6'h25, FN_SLT = 6'h2A;

    state_t      state, state_nx;
    logic [31:0] pc, ir, a, b, alu_out, mdr, tgt;
    logic [31:0] regs [32];

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, wr_idx;
    logic [31:0] imm_sx, alu_res, wr_data;
    logic        is_r, is_j, is_beq, is_addi, is_lw, is_sw, funct_ok, legal, misaligned;

    assign opcode  = ir[31:26];
    assign rs      = ir[25:21];
    assign rt      = ir[20:16];
    assign rd      = ir[15:11];
    assign funct   = ir[5:0];
    assign imm_sx  = {{16{ir[15]}}, ir[15:0]};
    assign is_r    = (opcode == OP_R);
    assign is_j    = (opcode == OP_J);
    assign is_beq  = (opcode == OP_BEQ);
    assign is_addi = (opcode == OP_ADDI);
    assign is_lw   = (opcode == OP_LW);
    assign is_sw   = (opcode == OP_SW);
    assign funct_ok = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    assign legal   = (is_r && funct_ok) || is_j || is_beq || is_addi || is_lw || is_sw;

    // Non-R instructions that reach EXEC all want A + sext(imm)
    always_comb begin
        alu_res = a + imm_sx;
        if (is_r) begin
            case (funct)
                FN_SUB:  alu_res = a - b;
                FN_AND:  alu_res = a & b;
                FN_OR:   alu_res = a | b;
                FN_SLT:  alu_res = {31'd0, $signed(a) < $signed(b)};
                default: alu_res = a + b;
            endcase
        end
    end

    assign misaligned = (is_lw || is_sw) && (alu_res[1:0] != 2'b00);

    always_comb begin
        state_nx  = state;
        retire    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            S_BOOT: state_nx = S_FETCH;
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc;
                if (mem_ready) state_nx = S_DECODE;
            end
            S_DECODE: begin
                if (!legal) state_nx = S_TRAP;
                else if (is_j) begin
                    retire   = 1'b1;
                    state_nx = S_FETCH;
                end else state_nx = S_EXEC;
            end
            S_EXEC: begin
                if (is_beq) begin
                    retire   = 1'b1;
                    state_nx = S_FETCH;
                end else if (is_lw || is_sw)
                    state_nx = (TRAP_ON_UNALIGNED && misaligned) ? S_TRAP : S_MEM;
                else state_nx = S_WB;
            end
            S_MEM: begin
                mem_req   = 1'b1;
                mem_we    = is_sw;
                mem_addr  = alu_out;
                mem_wdata = is_sw ? b : '0;
                if (mem_ready) begin
                    retire   = is_sw;
                    state_nx = is_sw ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                retire   = 1'b1;
                state_nx = S_FETCH;
            end
            S_TRAP:  state_nx = S_TRAP;
            default: state_nx = S_TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_BOOT;
            pc      <= RESET_PC;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            mdr     <= '0;
            tgt     <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_FETCH: if (mem_ready) begin
                    ir <= mem_rdata;
                    pc <= pc + 32'd4;
                end
                // pc already holds PC+4 here, so both targets build from it
                S_DECODE: begin
                    a   <= regs[rs];
                    b   <= regs[rt];
                    tgt <= pc + {imm_sx[29:0], 2'b00};
                    if (is_j) pc <= {pc[31:28], ir[25:0], 2'b00};
                end
                S_EXEC: begin
                    alu_out <= (is_lw || is_sw) ? {alu_res[31:2], 2'b00} : alu_res;
                    if (is_beq && (a == b)) pc <= tgt;
                end
                S_MEM: if (mem_ready && is_lw) mdr <= mem_rdata;
                default: ;
            endcase
        end
    end

    assign wr_idx  = is_r ? rd : rt;
    assign wr_data = is_lw ? mdr : alu_out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (state == S_WB && wr_idx != 5'd0) begin
            regs[wr_idx] <= wr_data;
        end
    end

    assign pc_out    = pc;
    assign halted    = (state == S_TRAP);
    assign dbg_rdata = regs[dbg_raddr];
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: directed programs plus a random program,
// checked against an instruction-level interpreter of the ISA subset.
module tb_mips_multicycle_core;
    logic clk = 1'b0, reset = 1'b0, reset0 = 1'b0;
    always #5 clk = ~clk;

    logic        mem_req, mem_we, retire, halted;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr, mem_wdata, pc_out, dbg_rdata;
    logic [31:0] mem_rdata = '0;
    logic [4:0]  dbg_raddr = '0, dbg_raddr0 = '0;
    logic        mem_req0, mem_we0, retire0, halted0, mem_ready0;
    logic [31:0] mem_addr0, mem_wdata0, mem_rdata0, pc_out0, dbg_rdata0;

    mips_multicycle_core #(.RESET_PC(32'h0), .TRAP_ON_UNALIGNED(1'b1)) u_dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .retire(retire),
        .pc_out(pc_out), .halted(halted), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata));

    mips_multicycle_core #(.RESET_PC(32'h600), .TRAP_ON_UNALIGNED(1'b0)) u_dut0 (
        .clk(clk), .reset(reset0), .mem_req(mem_req0), .mem_we(mem_we0), .mem_addr(mem_addr0),
        .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0), .mem_ready(mem_ready0), .retire(retire0),
        .pc_out(pc_out0), .halted(halted0), .dbg_raddr(dbg_raddr0), .dbg_rdata(dbg_rdata0));

    int n_tests = 0, n_fail = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [31:0] mem [1024];
    logic [31:0] ref_mem [1024];
    logic [31:0] ref_r [32];
    logic [31:0] ref_pc;
    int wait_lo = 0, wait_hi = 0, wait_cnt = 0, w_mark = 0, cnt = 0;
    bit noise = 0, busy = 0;
    logic [31:0] q_addr, q_wdata;
    logic        q_we;

    // Main-port memory: random wait states, request-hold checking, noise when idle
    always @(negedge clk) begin
        if (!reset || !mem_req) begin
            busy = 0;
            mem_ready = noise ? 1'($urandom) : 1'b0;
            mem_rdata = noise ? $urandom : 32'h0;
            if (!reset) wait_cnt = 0;
        end else begin
            if (!busy) begin
                busy = 1;
                cnt = $urandom_range(wait_hi, wait_lo);
                q_addr = mem_addr; q_we = mem_we; q_wdata = mem_wdata;
                chk("addr_align", {30'd0, mem_addr[1:0]}, 32'd0);
            end else begin
                chk("hold_addr", mem_addr, q_addr);
                chk("hold_we", {31'd0, mem_we}, {31'd0, q_we});
                chk("hold_wdata", mem_wdata, q_wdata);
            end
            if (cnt == 0) begin
                mem_ready = 1'b1;
                busy = 0;
                mem_rdata = mem[mem_addr[11:2]];
                if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = noise ? $urandom : 32'h0;
                cnt--;
                wait_cnt++;
            end
        end
    end

    // Second core: zero-wait read-only memory, watch for its data access
    assign mem_ready0 = mem_req0;
    assign mem_rdata0 = mem[mem_addr0[11:2]];
    bit seen40 = 0;
    logic we40 = 1'b1;
    always @(negedge clk) if (mem_req0 && mem_addr0 == 32'h40) begin
        seen40 = 1;
        we40 = mem_we0;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction
    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction
    function automatic logic [31:0] enc_j(input int adr);
        return {6'h02, 26'(adr)};
    endfunction

    // ISA interpreter: executes one instruction at ref_pc, reports dest and expected CPI
    task automatic ref_step(output int dest, output int base, output bit legal);
        logic [31:0] ir, pc4, imm, a, b, addr, val;
        int rs, rt, rd;
        ir = ref_mem[ref_pc[11:2]];
        pc4 = ref_pc + 32'd4;
        rs = int'(ir[25:21]); rt = int'(ir[20:16]); rd = int'(ir[15:11]);
        imm = {{16{ir[15]}}, ir[15:0]};
        a = ref_r[rs]; b = ref_r[rt];
        legal = 1; dest = 0; base = 0; val = 0;
        ref_pc = pc4;
        case (ir[31:26])
            6'h00: begin
                base = 4; dest = rd;
                case (ir[5:0])
                    6'h20: val = a + b;
                    6'h22: val = a - b;
                    6'h24: val = a & b;
                    6'h25: val = a | b;
                    6'h2A: val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: legal = 0;
                endcase
            end
            6'h08: begin base = 4; dest = rt; val = a + imm; end
            6'h23: begin
                base = 5; addr = a + imm;
                if (addr[1:0] != 2'b00) legal = 0;
                else begin dest = rt; val = ref_mem[addr[11:2]]; end
            end
            6'h2B: begin
                base = 4; addr = a + imm;
                if (addr[1:0] != 2'b00) legal = 0;
                else ref_mem[addr[11:2]] = b;
            end
            6'h04: begin base = 3; if (a == b) ref_pc = pc4 + (imm << 2); end
            6'h02: begin base = 2; ref_pc = {pc4[31:28], ir[25:0], 2'b00}; end
            default: legal = 0;
        endcase
        if (legal && dest != 0) ref_r[dest] = val;
    endtask

    task automatic rd_reg(input int r, output logic [31:0] v);
        dbg_raddr = 5'(r);
        #1 v = dbg_rdata;
    endtask

    // Reset, release and align to negedge+1 of the first FETCH cycle
    task automatic start_core();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        ref_pc = 32'h0;
        for (int i = 0; i < 32; i++) ref_r[i] = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
        reset = 1'b1;
        #1 chk("boot_noreq", {31'd0, mem_req}, 32'd0);
        @(posedge clk);
        #1 w_mark = wait_cnt;
        @(negedge clk);
        #1 chk("first_req", {31'd0, mem_req}, 32'd1);
        chk("first_addr", mem_addr, 32'h0);
    endtask

    // Entered at negedge+1 of an instruction's first cycle; leaves at the next one
    task automatic run_instr(input string tag, output int cyc);
        int dest, base;
        bit legal;
        ref_step(dest, base, legal);
        cyc = 1;
        while (!retire && !halted && cyc < 400) begin
            @(negedge clk);
            #1 cyc++;
        end
        if (legal) begin
            chk({tag, ".retire"}, {31'd0, retire}, 32'd1);
            chk({tag, ".cycles"}, 32'(cyc), 32'(base + wait_cnt - w_mark));
            w_mark = wait_cnt;
            @(negedge clk);
            #1 chk({tag, ".pc"}, pc_out, ref_pc);
            dbg_raddr = 5'(dest);
            #1 chk({tag, ".rd"}, dbg_rdata, ref_r[dest]);
        end else begin
            chk({tag, ".halt"}, {31'd0, halted}, 32'd1);
            chk({tag, ".noret"}, {31'd0, retire}, 32'd0);
            chk({tag, ".noreq"}, {31'd0, mem_req}, 32'd0);
            chk({tag, ".pc"}, pc_out, ref_pc);
        end
    endtask

    function automatic logic [31:0] rnd_instr(input int idx);
        int fns[5] = '{'h20, 'h22, 'h24, 'h25, 'h2A};
        int k, rs, rt, rd;
        k = $urandom_range(9, 0);
        rs = $urandom_range(31, 0); rt = $urandom_range(31, 0); rd = $urandom_range(31, 0);
        case (k)
            0, 1, 2, 3, 4: return enc_r(rs, rt, rd, fns[$urandom_range(4, 0)]);
            5: return enc_i('h08, rs, rt, int'($urandom_range(65535, 0)));
            6: return enc_i('h23, 0, rt, 'h800 + 4 * int'($urandom_range(511, 0)));
            7: return enc_i('h2B, 0, rt, 'h800 + 4 * int'($urandom_range(511, 0)));
            8: return enc_i('h04, rs, ($urandom_range(1, 0) != 0) ? rs : rt,
                             int'($urandom_range(510, 0)) - (idx + 1));
            default: return enc_j(int'($urandom_range(510, 0)));
        endcase
    endfunction

    initial begin
        int cyc, nbad;
        logic [31:0] v;
        for (int i = 0; i < 1024; i++) mem[i] = '0;

        // Core with unaligned forcing: lw $5,0x41($0) must read word 0x40
        mem['h10] = 32'h1234_5678;
        mem['h180] = enc_i('h23, 0, 5, 'h41);
        mem['h181] = enc_j('h181);
        repeat (2) @(negedge clk);
        reset0 = 1'b1;
        repeat (30) @(negedge clk);
        #1 chk("u0.seen40", {31'd0, seen40}, 32'd1);
        chk("u0.rd40", {31'd0, we40}, 32'd0);
        chk("u0.halted", {31'd0, halted0}, 32'd0);
        chk("u0.pc", {31'd0, (pc_out0 == 32'h604 || pc_out0 == 32'h608)}, 32'd1);
        dbg_raddr0 = 5'd5;
        #1 chk("u0.r5", dbg_rdata0, 32'h1234_5678);
        reset0 = 1'b0;

        // Reset state
        #1 chk("rst.req", {31'd0, mem_req}, 32'd0);
        chk("rst.we", {31'd0, mem_we}, 32'd0);
        chk("rst.addr", mem_addr, 32'd0);
        chk("rst.wdata", mem_wdata, 32'd0);
        chk("rst.retire", {31'd0, retire}, 32'd0);
        chk("rst.halted", {31'd0, halted}, 32'd0);
        chk("rst.pc", pc_out, 32'd0);

        // Directed program
        mem[0] = enc_i('h08, 0, 1, 5);      mem[1] = enc_i('h08, 0, 2, -3);
        mem[2] = enc_r(1, 2, 3, 'h20);      mem[3] = enc_r(2, 1, 4, 'h22);
        mem[4] = enc_i('h23, 0, 3, 'h44);   mem[5] = enc_i('h2B, 0, 3, 'h40);
        mem[6] = enc_i('h23, 0, 5, 'h40);   mem[7] = enc_i('h08, 0, 0, 7);
        mem[8] = enc_i('h04, 1, 1, 2);      mem[11] = enc_i('h04, 1, 2, 5);
        mem[12] = enc_j('h100);
        mem['h100] = enc_i('h08, 0, 1, -1); mem['h101] = enc_i('h08, 0, 2, 1);
        mem['h102] = enc_r(1, 2, 6, 'h2A);  mem['h103] = enc_r(2, 1, 7, 'h2A);
        mem['h104] = 32'hFC00_0000;
        mem['h10] = 32'h0;                  mem['h11] = 32'hDEAD_BEEF;
        start_core();
        for (int i = 0; i < 4; i++) begin
            run_instr("alu", cyc);
            chk("alu.cpi", 32'(cyc), 32'd4);
        end
        rd_reg(3, v); chk("add.r3", v, 32'd2);
        rd_reg(4, v); chk("sub.r4", v, 32'hFFFF_FFF8);
        chk("alu.pc", pc_out, 32'h10);
        run_instr("lw3", cyc);
        wait_lo = 3; wait_hi = 3;
        run_instr("sw", cyc);
        run_instr("lw5", cyc);
        chk("lw5.cycles", 32'(cyc), 32'd11);
        rd_reg(5, v); chk("lw5.val", v, 32'hDEAD_BEEF);
        wait_lo = 0; wait_hi = 0;
        run_instr("addi0", cyc);
        rd_reg(0, v); chk("r0.zero", v, 32'd0);
        run_instr("beq_t", cyc);  chk("beq_t.pc", pc_out, 32'h2C);
        run_instr("beq_n", cyc);  chk("beq_n.pc", pc_out, 32'h30);
        run_instr("j", cyc);      chk("j.pc", pc_out, 32'h400);
        for (int i = 0; i < 4; i++) run_instr("slt", cyc);
        rd_reg(6, v); chk("slt.lt", v, 32'd1);
        rd_reg(7, v); chk("slt.ge", v, 32'd0);
        run_instr("illegal", cyc);
        nbad = 0;
        repeat (10) begin
            @(negedge clk);
            #1 if (mem_req || retire || !halted) nbad++;
        end
        chk("trap.quiet", 32'(nbad), 32'd0);

        // Misaligned load traps; registers clear on reset
        mem[0] = enc_i('h23, 0, 5, 'h41);
        start_core();
        rd_reg(1, v); chk("rst.r1", v, 32'd0);
        run_instr("unalign", cyc);

        // Reset during a fetch wait drops the request immediately
        mem[0] = enc_i('h08, 0, 1, 5);
        wait_lo = 6; wait_hi = 6;
        start_core();
        repeat (3) @(negedge clk);
        #1 chk("midf.req", {31'd0, mem_req}, 32'd1);
        reset = 1'b0;
        #1 chk("midf.drop", {31'd0, mem_req}, 32'd0);
        chk("midf.pc", pc_out, 32'h0);
        wait_lo = 0; wait_hi = 0;
        start_core();
        run_instr("restart", cyc);

        // Random program with random wait states and idle-bus noise
        for (int i = 0; i < 511; i++) mem[i] = rnd_instr(i);
        mem[511] = enc_j(0);
        for (int i = 512; i < 1024; i++) mem[i] = $urandom;
        wait_lo = 0; wait_hi = 3; noise = 1;
        start_core();
        for (int i = 0; i < 300; i++) run_instr("rnd", cyc);
        noise = 0;
        for (int r = 0; r < 32; r++) begin
            rd_reg(r, v);
            chk("rnd.regfile", v, ref_r[r]);
        end
        nbad = 0;
        for (int i = 512; i < 1024; i++) if (mem[i] !== ref_mem[i]) nbad++;
        chk("rnd.dmem", 32'(nbad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
